// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: one shift-add or restoring
// shift-subtract step per cycle, results written to HI/LO after sign fixup.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic             r_div, r_neg_q, r_neg_r, r_div0;
  logic [WIDTH-1:0] r_a, r_acc, r_q, r_hi, r_lo;

  logic             w_busy, w_accept, w_last;
  logic             w_signed, w_sign1, w_sign2;
  logic [WIDTH-1:0] w_mag1, w_mag2;
  logic [WIDTH:0]   w_sum, w_shift, w_diff;
  logic [WIDTH-1:0] w_acc_nxt, w_q_nxt, w_hi_fix, w_lo_fix;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last = (r_cnt == CntLast);

  // Next-state logic; flush overrides everything, including a same-cycle start
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (start) w_state_nxt = StCalc;
        StCalc:  if (w_last) w_state_nxt = StDone;
        StDone:  w_state_nxt = start ? StCalc : StIdle;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_busy = (r_state == StCalc);
    busy   = w_busy;
    done   = (r_state == StDone);
    stall  = w_busy | (start & ~w_busy);
  end

  assign w_accept = start & ~flush & (r_state != StCalc);

  // Operand conditioning: signed ops work on magnitudes, signs kept for fixup
  always_comb begin
    w_signed = ~op[0];
    w_sign1  = w_signed & ReadData1[WIDTH-1];
    w_sign2  = w_signed & ReadData2[WIDTH-1];
    w_mag1   = w_sign1 ? -ReadData1 : ReadData1;
    w_mag2   = w_sign2 ? -ReadData2 : ReadData2;
  end

  // One iteration step; r_q holds the multiplier / dividend and collects the result
  always_comb begin
    w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : '0);
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_a};
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_nxt = w_diff[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shift[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_sum[WIDTH:1];
      w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    end
  end

  // Sign fixup of the final step; divide by zero forces an all-ones quotient
  always_comb begin
    w_prod     = {w_acc_nxt, w_q_nxt};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    if (r_div) begin
      w_hi_fix = r_neg_r ? -w_acc_nxt : w_acc_nxt;
      w_lo_fix = r_div0 ? '1 : (r_neg_q ? -w_q_nxt : w_q_nxt);
    end else begin
      w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod_fix[WIDTH-1:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_a     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_div   <= op[1];
      r_neg_q <= w_sign1 ^ w_sign2;
      r_neg_r <= w_sign1;
      r_div0  <= op[1] & (ReadData2 == '0);
      r_a     <= op[1] ? w_mag2 : w_mag1;
      r_q     <= op[1] ? w_mag1 : w_mag2;
      r_acc   <= '0;
    end else if ((r_state == StCalc) && !flush) begin
      r_cnt <= r_cnt + CntW'(1);
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      if (w_last) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule
